// File: rtl/stack_sequencer_pkg.sv
// Shared types for the stack push/pop sequencer: STACK_* word bitmask layout
// and the sequencer state encoding.
package stack_sequencer_pkg;

    localparam int unsigned STACK_W = 16;

    // Push walks these low-to-high, pop walks them high-to-low.
    localparam logic [15:0] STACK_AW         = 16'h0001;
    localparam logic [15:0] STACK_CW         = 16'h0002;
    localparam logic [15:0] STACK_DW         = 16'h0004;
    localparam logic [15:0] STACK_BW         = 16'h0008;
    localparam logic [15:0] STACK_SP         = 16'h0010;
    localparam logic [15:0] STACK_BP         = 16'h0020;
    localparam logic [15:0] STACK_IX         = 16'h0040;
    localparam logic [15:0] STACK_IY         = 16'h0080;
    localparam logic [15:0] STACK_BP_SKIP_SP = 16'h0100;
    localparam logic [15:0] STACK_PS         = 16'h0200;
    localparam logic [15:0] STACK_PC         = 16'h0400;
    localparam logic [15:0] STACK_OPERAND    = 16'h0800;

    localparam logic [3:0] STACK_IDX_SP         = 4'd4;
    localparam logic [3:0] STACK_IDX_BP_SKIP_SP = 4'd8;
    localparam logic [3:0] STACK_IDX_OPERAND    = 4'd11;

    localparam logic [15:0] STACK_STEP = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_SCAN,
        ST_PUSH_BUS,
        ST_POP_SCAN,
        ST_POP_BUS,
        ST_DONE
    } stack_seq_state_e;

    function automatic logic [15:0] stack_bit(input logic [3:0] idx);
        return 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/stack_sequencer_bit_select.sv
// Combinational set-bit encoder: lowest set bit when dir_i=0, highest when dir_i=1.
module stack_bit_select (
    input  logic [15:0] mask_i,
    input  logic        dir_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o   = 4'd0;
        valid_o = |mask_i;
        if (dir_i) begin
            for (int i = 0; i < 16; i++) begin
                if (mask_i[i]) idx_o = 4'(i);
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (mask_i[i]) idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Push/pop sequencer: walks STACK_* masks one word at a time, driving SS-relative
// bus accesses, register writeback and SP update strobes.
module stack_sequencer
    import stack_sequencer_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [15:0] push_mask_i,
    input  logic [15:0] pop_mask_i,
    input  logic [15:0] sp_in_i,
    input  logic [15:0] operand_in_i,
    output logic [3:0]  reg_sel_o,
    input  logic [15:0] reg_rdata_i,
    output logic        reg_we_o,
    output logic [15:0] reg_wdata_o,
    output logic        sp_we_o,
    output logic [15:0] sp_wdata_o,
    output logic        bus_req_o,
    output logic        bus_write_o,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [15:0] bus_rdata_i,
    output logic        busy_o,
    output logic        done_o
);

    stack_seq_state_e state_q, state_d;
    logic [15:0] push_mask_q, push_mask_d;
    logic [15:0] pop_mask_q, pop_mask_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] sp_in_q, sp_in_d;
    logic [15:0] operand_q, operand_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] wdata_q, wdata_d;

    logic        pop_phase;
    logic [15:0] sel_mask;
    logic [3:0]  sel_idx;
    logic        sel_valid;
    logic [15:0] sp_dec, sp_inc;

    assign pop_phase = (state_q == ST_POP_SCAN) || (state_q == ST_POP_BUS);
    assign sel_mask  = pop_phase ? pop_mask_q : push_mask_q;
    assign sp_dec    = sp_q - STACK_STEP;
    assign sp_inc    = sp_q + STACK_STEP;

    stack_bit_select u_bit_select (
        .mask_i  (sel_mask),
        .dir_i   (pop_phase),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            push_mask_q <= '0;
            pop_mask_q  <= '0;
            sp_q        <= '0;
            sp_in_q     <= '0;
            operand_q   <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            push_mask_q <= push_mask_d;
            pop_mask_q  <= pop_mask_d;
            sp_q        <= sp_d;
            sp_in_q     <= sp_in_d;
            operand_q   <= operand_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        push_mask_d = push_mask_q;
        pop_mask_d  = pop_mask_q;
        sp_d        = sp_q;
        sp_in_d     = sp_in_q;
        operand_d   = operand_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    push_mask_d = push_mask_i;
                    pop_mask_d  = pop_mask_i;
                    sp_d        = sp_in_i;
                    sp_in_d     = sp_in_i;
                    operand_d   = operand_in_i;
                    state_d     = ST_PUSH_SCAN;
                end
            end
            ST_PUSH_SCAN: begin
                if (!sel_valid) begin
                    state_d = ST_POP_SCAN;
                end else if (sel_idx == STACK_IDX_BP_SKIP_SP) begin
                    push_mask_d = push_mask_q & ~stack_bit(sel_idx);
                end else begin
                    // Capture write data now; reg_rdata follows reg_sel only during the scan.
                    idx_d = sel_idx;
                    if (sel_idx == STACK_IDX_SP)           wdata_d = sp_in_q;
                    else if (sel_idx == STACK_IDX_OPERAND) wdata_d = operand_q;
                    else                                   wdata_d = reg_rdata_i;
                    state_d = ST_PUSH_BUS;
                end
            end
            ST_PUSH_BUS: begin
                if (bus_ack_i) begin
                    push_mask_d = push_mask_q & ~stack_bit(idx_q);
                    sp_d        = sp_dec;
                    state_d     = ST_PUSH_SCAN;
                end
            end
            ST_POP_SCAN: begin
                if (!sel_valid) begin
                    state_d = ST_DONE;
                end else if (sel_idx == STACK_IDX_BP_SKIP_SP) begin
                    pop_mask_d = pop_mask_q & ~stack_bit(sel_idx);
                    sp_d       = sp_inc;
                end else begin
                    idx_d   = sel_idx;
                    state_d = ST_POP_BUS;
                end
            end
            ST_POP_BUS: begin
                if (bus_ack_i) begin
                    pop_mask_d = pop_mask_q & ~stack_bit(idx_q);
                    sp_d       = sp_inc;
                    state_d    = ST_POP_SCAN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Every strobe is gated by reset so an abort takes effect in the same cycle.
    always_comb begin
        reg_sel_o   = idx_q;
        reg_we_o    = 1'b0;
        reg_wdata_o = '0;
        sp_we_o     = 1'b0;
        sp_wdata_o  = sp_q;
        bus_req_o   = 1'b0;
        bus_write_o = 1'b0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        if (!reset_i) begin
            busy_o = (state_q != ST_IDLE);
            done_o = (state_q == ST_DONE);
            unique case (state_q)
                ST_PUSH_SCAN: reg_sel_o = sel_idx;
                ST_PUSH_BUS: begin
                    bus_req_o   = 1'b1;
                    bus_write_o = 1'b1;
                    bus_addr_o  = sp_dec;
                    bus_wdata_o = wdata_q;
                    if (bus_ack_i) begin
                        sp_we_o    = 1'b1;
                        sp_wdata_o = sp_dec;
                    end
                end
                ST_POP_SCAN: begin
                    reg_sel_o = sel_idx;
                    if (sel_valid && sel_idx == STACK_IDX_BP_SKIP_SP) begin
                        sp_we_o    = 1'b1;
                        sp_wdata_o = sp_inc;
                    end
                end
                ST_POP_BUS: begin
                    bus_req_o  = 1'b1;
                    bus_addr_o = sp_q;
                    if (bus_ack_i) begin
                        sp_we_o     = 1'b1;
                        sp_wdata_o  = sp_inc;
                        reg_we_o    = (idx_q != STACK_IDX_SP);
                        reg_wdata_o = bus_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
